// File: rtl/sample_packer_pkg.sv
// Shared definitions for the sample packer, the packet streamer and the
// firmware register map: mode encodings, slot counts and slice widths.
package sample_packer_pkg;

   localparam int SAMPLE_BITS    = 4;
   localparam int PACK_WORD_BITS = 16;

   localparam logic [1:0] MODE_CH1  = 2'd0;
   localparam logic [1:0] MODE_CH13 = 2'd1;
   localparam logic [1:0] MODE_ALL  = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   localparam logic [2:0] SLOTS_CH1  = 3'd4;
   localparam logic [2:0] SLOTS_CH13 = 3'd2;
   localparam logic [2:0] SLOTS_ALL  = 3'd1;

   typedef enum logic [1:0] {
      SLICE_W4  = 2'd0,
      SLICE_W8  = 2'd1,
      SLICE_W16 = 2'd2
   } slice_width_e;

   // The reserved encoding behaves as the two-channel mode.
   function automatic logic [1:0] normalize_mode(input logic [1:0] m);
      return (m == MODE_RSVD) ? MODE_CH13 : m;
   endfunction

   // Phase value of the final slot of a word for the given applied mode.
   function automatic logic [1:0] last_slot(input logic [1:0] m);
      logic [2:0] n;
      case (m)
         MODE_CH1: n = SLOTS_CH1;
         MODE_ALL: n = SLOTS_ALL;
         default:  n = SLOTS_CH13;
      endcase
      return 2'(n - 3'd1);
   endfunction

endpackage

// File: rtl/sample_packer_slice_select.sv
// Builds the per-sample slice for the applied mode, right-aligned, earliest
// channel in the MSBs, together with a code for how many bits it carries.
module slice_select
   import sample_packer_pkg::*;
(
   input  logic [1:0]                mode_active,
   input  logic [SAMPLE_BITS-1:0]    ch1_s,
   input  logic [SAMPLE_BITS-1:0]    ch2_s,
   input  logic [SAMPLE_BITS-1:0]    ch3_s,
   input  logic [SAMPLE_BITS-1:0]    ch4_s,
   output logic [PACK_WORD_BITS-1:0] slice,
   output slice_width_e              slice_width
);

   // Channel-set decode; mode_active is already normalized so 3 never occurs.
   always_comb begin
      slice       = '0;
      slice_width = SLICE_W8;
      case (mode_active)
         MODE_CH1: begin
            slice       = {{(PACK_WORD_BITS-SAMPLE_BITS){1'b0}}, ch1_s};
            slice_width = SLICE_W4;
         end
         MODE_ALL: begin
            slice       = {ch1_s, ch2_s, ch3_s, ch4_s};
            slice_width = SLICE_W16;
         end
         default: begin
            slice       = {{(PACK_WORD_BITS-2*SAMPLE_BITS){1'b0}}, ch1_s, ch3_s};
            slice_width = SLICE_W8;
         end
      endcase
   end

endmodule

// File: rtl/sample_packer.sv
// Packs quantizer slices into 16-bit words for the packet streamer. The mode
// is only re-sampled when the next cycle starts a fresh word, so a word is
// always built from a single channel set.
module sample_packer #(
   parameter int WORD_BITS   = 16,
   parameter int SAMPLE_BITS = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic [SAMPLE_BITS-1:0] ch1_s,
   input  logic [SAMPLE_BITS-1:0] ch2_s,
   input  logic [SAMPLE_BITS-1:0] ch3_s,
   input  logic [SAMPLE_BITS-1:0] ch4_s,
   output logic [WORD_BITS-1:0]   out_data,
   output logic                   out_en,
   output logic [31:0]            word_count,
   output logic [1:0]             mode_active
);
   import sample_packer_pkg::*;

   logic [1:0]           mode_active_q;
   logic [1:0]           phase_q;
   logic [WORD_BITS-1:0] shift_q;
   logic [WORD_BITS-1:0] out_data_q;
   logic                 out_en_q;
   logic [31:0]          word_count_q;

   logic [WORD_BITS-1:0] slice;
   slice_width_e         slice_width;
   logic [WORD_BITS-1:0] packed_next;
   logic                 last_slot_hit;
   logic                 word_done;

   slice_select u_slice_select (
      .mode_active (mode_active_q),
      .ch1_s       (ch1_s),
      .ch2_s       (ch2_s),
      .ch3_s       (ch3_s),
      .ch4_s       (ch4_s),
      .slice       (slice),
      .slice_width (slice_width)
   );

   // Shift the partial word up by one slice and append the current slice.
   always_comb begin
      packed_next = slice;
      case (slice_width)
         SLICE_W4: packed_next = (shift_q << 4) | slice;
         SLICE_W8: packed_next = (shift_q << 8) | slice;
         default:  packed_next = slice;
      endcase
      last_slot_hit = (phase_q == last_slot(mode_active_q));
      word_done     = enable && last_slot_hit;
   end

   // Phase counter and partial-word shift register; cleared between words.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= '0;
         shift_q <= '0;
      end else if (!enable || last_slot_hit) begin
         phase_q <= '0;
         shift_q <= '0;
      end else begin
         phase_q <= phase_q + 2'd1;
         shift_q <= packed_next;
      end
   end

   // Re-sample the mode whenever the next cycle begins a word (or idle).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_active_q <= MODE_CH1;
      end else if (!enable || last_slot_hit) begin
         mode_active_q <= normalize_mode(mode);
      end
   end

   // Registered word output and its one-cycle strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data_q <= '0;
         out_en_q   <= 1'b0;
      end else begin
         out_en_q <= word_done;
         if (word_done) begin
            out_data_q <= packed_next;
         end
      end
   end

   // Running count of emitted words, wrapping silently at 2^32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_count_q <= '0;
      end else begin
         word_count_q <= word_count_q + {31'd0, word_done};
      end
   end

   assign out_data    = out_data_q;
   assign out_en      = out_en_q;
   assign word_count  = word_count_q;
   assign mode_active = mode_active_q;

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: directed vector table, hand-written corner
// sequences and randomized traffic checked against a nibble-queue model.
module tb_sample_packer;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [1:0]  mode;
   logic [3:0]  ch1_s, ch2_s, ch3_s, ch4_s;
   logic [15:0] out_data;
   logic        out_en;
   logic [31:0] word_count;
   logic [1:0]  mode_active;

   int checks;
   int failures;

   sample_packer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .mode        (mode),
      .ch1_s       (ch1_s),
      .ch2_s       (ch2_s),
      .ch3_s       (ch3_s),
      .ch4_s       (ch4_s),
      .out_data    (out_data),
      .out_en      (out_en),
      .word_count  (word_count),
      .mode_active (mode_active)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: nibbles of the word in progress, in arrival order
   logic [3:0]  m_nib[$];
   logic [1:0]  m_mode;
   logic [15:0] m_data;
   logic        m_en;
   logic [31:0] m_count;
   logic [15:0] exp_q[$];

   function automatic logic [1:0] norm(input logic [1:0] m);
      return (m == 2'd3) ? 2'd1 : m;
   endfunction

   task automatic model_reset();
      m_nib.delete();
      m_mode  = 2'd0;
      m_data  = 16'h0;
      m_en    = 1'b0;
      m_count = 32'd0;
      exp_q.delete();
   endtask

   task automatic model_edge();
      m_en = 1'b0;
      if (!enable) begin
         m_nib.delete();
         m_mode = norm(mode);
      end else begin
         m_nib.push_back(ch1_s);
         if (m_mode == 2'd1) begin
            m_nib.push_back(ch3_s);
         end else if (m_mode == 2'd2) begin
            m_nib.push_back(ch2_s);
            m_nib.push_back(ch3_s);
            m_nib.push_back(ch4_s);
         end
         if (m_nib.size() == 4) begin
            m_data  = {m_nib[0], m_nib[1], m_nib[2], m_nib[3]};
            m_en    = 1'b1;
            m_count = m_count + 32'd1;
            m_nib.delete();
            m_mode  = norm(mode);
            exp_q.push_back(m_data);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic [15:0] w;
      chk("model_out_en", 32'(out_en), 32'(m_en));
      chk("model_word_count", word_count, m_count);
      chk("model_mode_active", 32'(mode_active), 32'(m_mode));
      chk("model_out_data_hold", 32'(out_data), 32'(m_data));
      if (out_en) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_unexpected_word", 32'(out_data), 32'hDEAD_0000);
         end else begin
            w = exp_q.pop_front();
            chk("scoreboard_word", 32'(out_data), 32'(w));
         end
      end
   endtask

   // driver: apply inputs, let one active edge pass, sample #1 after it
   task automatic step(input logic e, input logic [1:0] m,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
      enable = e;
      mode   = m;
      ch1_s  = a;
      ch2_s  = b;
      ch3_s  = c;
      ch4_s  = d;
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   typedef struct {
      logic        en;
      logic [1:0]  md;
      logic [3:0]  c1, c2, c3, c4;
      logic        exp_en;
      logic [15:0] exp_data;
      logic [31:0] exp_cnt;
      logic [1:0]  exp_ma;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [31:0] cnt_before;
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      enable   = 1'b0;
      mode     = 2'd0;
      ch1_s    = '0;
      ch2_s    = '0;
      ch3_s    = '0;
      ch4_s    = '0;
      model_reset();

      vecs[0] = '{1'b0, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 32'd0, 2'd1};
      vecs[1] = '{1'b1, 2'd1, 4'hA, 4'hF, 4'h5, 4'hF, 1'b0, 16'h0000, 32'd0, 2'd1};
      vecs[2] = '{1'b1, 2'd1, 4'h3, 4'hE, 4'hC, 4'hE, 1'b1, 16'hA53C, 32'd1, 2'd1};
      vecs[3] = '{1'b1, 2'd1, 4'h1, 4'h0, 4'h2, 4'h0, 1'b0, 16'hA53C, 32'd1, 2'd1};
      vecs[4] = '{1'b1, 2'd2, 4'h4, 4'h9, 4'h8, 4'h9, 1'b1, 16'h1248, 32'd2, 2'd2};
      vecs[5] = '{1'b1, 2'd2, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 16'h1234, 32'd3, 2'd2};
      vecs[6] = '{1'b1, 2'd2, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1, 16'h5678, 32'd4, 2'd2};
      vecs[7] = '{1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h5678, 32'd4, 2'd0};

      // reset
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_data", 32'(out_data), 32'h0);
      chk("reset_out_en", 32'(out_en), 32'h0);
      chk("reset_word_count", word_count, 32'h0);
      chk("reset_mode_active", 32'(mode_active), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // table-driven vectors
      for (int i = 0; i < 8; i++) begin
         step(vecs[i].en, vecs[i].md, vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].c4);
         chk($sformatf("vec%0d_out_en", i), 32'(out_en), 32'(vecs[i].exp_en));
         chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
         chk($sformatf("vec%0d_word_count", i), word_count, vecs[i].exp_cnt);
         chk($sformatf("vec%0d_mode_active", i), 32'(mode_active), 32'(vecs[i].exp_ma));
      end

      // reset asserted mid-word takes effect without a clock edge
      step(1'b1, 2'd0, 4'h7, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h7, 4'h0, 4'h0, 4'h0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_out_data", 32'(out_data), 32'h0);
      chk("async_reset_out_en", 32'(out_en), 32'h0);
      chk("async_reset_word_count", word_count, 32'h0);
      chk("async_reset_mode_active", 32'(mode_active), 32'h0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b1, 2'd0, 4'h1, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h2, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h3, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h4, 4'h0, 4'h0, 4'h0);
      chk("post_reset_word", 32'(out_data), 32'h1234);
      chk("post_reset_count", word_count, 32'd1);

      // mid-word mode change: word finishes in mode 0, mode 2 from next word
      step(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h1, 4'hF, 4'hF, 4'hF);
      step(1'b1, 2'd0, 4'h2, 4'hF, 4'hF, 4'hF);
      step(1'b1, 2'd2, 4'h3, 4'hB, 4'hC, 4'hD);
      chk("modechg_still_mode0", 32'(mode_active), 32'd0);
      chk("modechg_no_strobe", 32'(out_en), 32'd0);
      step(1'b1, 2'd2, 4'h4, 4'hB, 4'hC, 4'hD);
      chk("modechg_word", 32'(out_data), 32'h1234);
      chk("modechg_strobe", 32'(out_en), 32'd1);
      chk("modechg_mode_active", 32'(mode_active), 32'd2);
      step(1'b1, 2'd2, 4'h5, 4'h6, 4'h7, 4'h8);
      chk("modechg_next_strobe", 32'(out_en), 32'd1);
      chk("modechg_next_word", 32'(out_data), 32'h5678);

      // enable drop discards the partial word
      step(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
      cnt_before = word_count;
      step(1'b1, 2'd0, 4'h1, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h2, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h3, 4'h0, 4'h0, 4'h0);
      step(1'b0, 2'd0, 4'h4, 4'h0, 4'h0, 4'h0);
      chk("drop_no_strobe", 32'(out_en), 32'd0);
      chk("drop_count_hold", word_count, cnt_before);
      step(1'b1, 2'd0, 4'h9, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h8, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h7, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'h6, 4'h0, 4'h0, 4'h0);
      chk("drop_rearm_word", 32'(out_data), 32'h9876);
      chk("drop_rearm_count", word_count, cnt_before + 32'd1);

      // reserved mode reads back and packs as mode 1
      step(1'b0, 2'd3, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("rsvd_mode_active", 32'(mode_active), 32'd1);
      step(1'b1, 2'd3, 4'hA, 4'h1, 4'h5, 4'h1);
      step(1'b1, 2'd3, 4'h3, 4'h1, 4'hC, 4'h1);
      chk("rsvd_strobe", 32'(out_en), 32'd1);
      chk("rsvd_word", 32'(out_data), 32'hA53C);

      // word count wrap via backdoor preload
      step(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
      force dut.word_count_q = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      step(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
      release dut.word_count_q;
      #1;
      chk("wrap_preload", word_count, 32'hFFFF_FFFF);
      step(1'b1, 2'd0, 4'hC, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'hA, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'hF, 4'h0, 4'h0, 4'h0);
      step(1'b1, 2'd0, 4'hE, 4'h0, 4'h0, 4'h0);
      chk("wrap_count_zero", word_count, 32'd0);
      chk("wrap_word", 32'(out_data), 32'hCAFE);

      // randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         logic [1:0] rm;
         rm = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : mode;
         step(($urandom_range(0, 9) != 0), rm,
              4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end
      step(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
